// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch control FSM: synchronised, debounced push-buttons produce release events that
// drive a Moore state machine for the time-counter enable, display freeze and counter clear.
module stopwatch_ctrl_fsm #(
  parameter int unsigned DEB_CYCLES     = 50000,
  parameter int unsigned LONG_CYCLES    = 100000000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter bit          PAUSE_TOGGLE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic       conta_tempo,
  output logic       pausa_display,
  output logic       zera_tempo,
  output logic [3:0] led,
  output logic [1:0] estado,
  output logic       evt_pulse
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_CONTANDO = 2'd1,
    S_PAUSADO  = 2'd2,
    S_PARADO   = 2'd3
  } state_t;

  // Event vector bit positions, also the priority order (highest index wins)
  localparam int EV_COUNT = 0;
  localparam int EV_PAUSE = 1;
  localparam int EV_STOP  = 2;
  localparam int EV_RESET = 3;

  logic [3:0] pressed_raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] deb_q, deb_d;
  logic [3:0] release_evt;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic          long_press;
  logic [3:0] evt_q, evt_d;

  state_t     state_q, state_d;
  logic       evt_pulse_q, evt_pulse_d;
  logic [3:0] led_q, led_d;
  logic       zera_q, zera_d;
  logic       conta_q, conta_d;
  logic       pausa_q, pausa_d;

  // Internally everything works on "pressed = 1"
  assign pressed_raw = BTN_ACTIVE_LOW ? ~btn : btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      logic [DW-1:0] cnt_q, cnt_d;
      logic          lvl_q, lvl_d;

      always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync2_q[gi] != lvl_q) begin
          if (cnt_q == DEB_LAST) begin
            lvl_d = sync2_q[gi];
          end else begin
            cnt_d = cnt_q + DEB_ONE;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          lvl_q <= lvl_d;
        end
      end

      assign deb_q[gi]       = lvl_q;
      assign deb_d[gi]       = lvl_d;
      assign release_evt[gi] = lvl_q & ~lvl_d;
    end
  endgenerate

  // Hold time includes the release edge, so a press debounced-held for LONG_CYCLES counts as long
  always_comb begin
    hold_inc = (hold_q == LONG_MAX) ? hold_q : hold_q + HOLD_ONE;
    hold_d   = (deb_q[0] && !release_evt[0]) ? hold_inc : '0;
  end

  assign long_press = (hold_inc == LONG_MAX);

  always_comb begin
    evt_d           = '0;
    evt_d[EV_RESET] = release_evt[3] | (release_evt[0] & long_press);
    evt_d[EV_STOP]  = release_evt[0] & ~long_press;
    evt_d[EV_PAUSE] = release_evt[1];
    evt_d[EV_COUNT] = release_evt[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      evt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      evt_q  <= evt_d;
    end
  end

  // State register (outputs are registered alongside it so they cannot glitch)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      evt_pulse_q <= 1'b0;
      led_q       <= 4'b1000;
      zera_q      <= 1'b1;
      conta_q     <= 1'b0;
      pausa_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      evt_pulse_q <= evt_pulse_d;
      led_q       <= led_d;
      zera_q      <= zera_d;
      conta_q     <= conta_d;
      pausa_q     <= pausa_d;
    end
  end

  // Next state: only the highest-priority event is considered; if it has no
  // transition from the current state it is simply dropped.
  always_comb begin
    state_d = state_q;
    if (evt_q[EV_RESET]) begin
      state_d = S_RESET;
    end else if (evt_q[EV_STOP]) begin
      if (state_q == S_CONTANDO || state_q == S_PAUSADO) begin
        state_d = S_PARADO;
      end
    end else if (evt_q[EV_PAUSE]) begin
      if (state_q == S_CONTANDO) begin
        state_d = S_PAUSADO;
      end else if (state_q == S_PAUSADO && PAUSE_TOGGLE) begin
        state_d = S_CONTANDO;
      end
    end else if (evt_q[EV_COUNT]) begin
      if (state_q != S_CONTANDO) begin
        state_d = S_CONTANDO;
      end
    end
    evt_pulse_d = (state_d != state_q);
  end

  // Output decode of the next state, captured by the state register
  always_comb begin
    led_d   = 4'b0000;
    zera_d  = 1'b0;
    conta_d = 1'b0;
    pausa_d = 1'b0;
    unique case (state_d)
      S_RESET: begin
        led_d  = 4'b1000;
        zera_d = 1'b1;
      end
      S_CONTANDO: begin
        led_d   = 4'b0100;
        conta_d = 1'b1;
      end
      S_PAUSADO: begin
        led_d   = 4'b0010;
        conta_d = 1'b1;
        pausa_d = 1'b1;
      end
      S_PARADO: begin
        led_d = 4'b0001;
      end
      default: begin
        led_d  = 4'b1000;
        zera_d = 1'b1;
      end
    endcase
  end

  assign estado        = state_q;
  assign led           = led_q;
  assign zera_tempo    = zera_q;
  assign conta_tempo   = conta_q;
  assign pausa_display = pausa_q;
  assign evt_pulse     = evt_pulse_q;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Bench for stopwatch_ctrl_fsm: two instances (pause toggle on/off) checked every cycle
// against a sliding-window debounce / event-priority model, plus literal spot checks.
module tb_stopwatch_ctrl_fsm;

  localparam int D = 4;
  localparam int L = 20;

  localparam int ST_RESET = 0;
  localparam int ST_CONT  = 1;
  localparam int ST_PAUS  = 2;
  localparam int ST_PARA  = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn   = 4'hF;

  logic       conta0, pausa0, zera0, evt0;
  logic [3:0] led0;
  logic [1:0] est0;
  logic       conta1, pausa1, zera1, evt1;
  logic [3:0] led1;
  logic [1:0] est1;

  always #5 clk = ~clk;

  stopwatch_ctrl_fsm #(.DEB_CYCLES(D), .LONG_CYCLES(L), .BTN_ACTIVE_LOW(1'b1), .PAUSE_TOGGLE(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .conta_tempo(conta0), .pausa_display(pausa0), .zera_tempo(zera0),
    .led(led0), .estado(est0), .evt_pulse(evt0)
  );

  stopwatch_ctrl_fsm #(.DEB_CYCLES(D), .LONG_CYCLES(L), .BTN_ACTIVE_LOW(1'b1), .PAUSE_TOGGLE(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .conta_tempo(conta1), .pausa_display(pausa1), .zera_tempo(zera1),
    .led(led1), .estado(est1), .evt_pulse(evt1)
  );

  int total   = 0;
  int bad     = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         samp [4][$];
  bit   [3:0] m_deb;
  bit   [3:0] m_ev;
  int         m_edge;
  int         m_press_edge;
  int         m_state [2];
  bit         m_pulse [2];

  // Highest fired event decides; transitions not defined for the state do nothing
  function automatic int apply_evt(input int s, input bit [3:0] ev, input bit toggle);
    if (ev[3]) return ST_RESET;
    if (ev[2]) return (s == ST_CONT || s == ST_PAUS) ? ST_PARA : s;
    if (ev[1]) begin
      if (s == ST_CONT) return ST_PAUS;
      if (s == ST_PAUS && toggle) return ST_CONT;
      return s;
    end
    if (ev[0]) return ST_CONT;
    return s;
  endfunction

  function automatic logic [9:0] exp_vec(input int s, input bit p);
    logic [3:0] one_hot;
    one_hot = 4'b1000 >> s;
    return {2'(s), one_hot, s == ST_RESET, (s == ST_CONT) || (s == ST_PAUS), s == ST_PAUS, p};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge       = 0;
      m_press_edge = 0;
      m_deb        = '0;
      m_ev         = '0;
      for (int k = 0; k < 2; k++) begin
        m_state[k] = ST_RESET;
        m_pulse[k] = 1'b0;
      end
      for (int b = 0; b < 4; b++) begin
        samp[b].delete();
        repeat (D + 2) samp[b].push_back(1'b0);
      end
    end else begin
      bit [3:0] flip;
      bit [3:0] rel;
      bit       long_p;
      int       nxt;
      m_edge++;
      for (int k = 0; k < 2; k++) begin
        nxt        = apply_evt(m_state[k], m_ev, (k == 0));
        m_pulse[k] = (nxt != m_state[k]);
        m_state[k] = nxt;
      end
      // A debounced level flips once the D synchronised samples (taken 2..D+1 edges ago) all disagree with it
      for (int b = 0; b < 4; b++) begin
        samp[b].push_back(~btn[b]);
        flip[b] = 1'b1;
        for (int j = 2; j <= D + 1; j++) begin
          if (samp[b][samp[b].size() - 1 - j] == m_deb[b]) flip[b] = 1'b0;
        end
        void'(samp[b].pop_front());
      end
      rel    = '0;
      long_p = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (flip[b]) begin
          if (m_deb[b]) rel[b] = 1'b1;
          else if (b == 0) m_press_edge = m_edge;
          m_deb[b] = ~m_deb[b];
        end
      end
      if (rel[0]) long_p = ((m_edge - m_press_edge) >= L);
      m_ev = {rel[3] | (rel[0] & long_p), rel[0] & ~long_p, rel[1], rel[2]};
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("dut0_outputs", {22'd0, est0, led0, zera0, conta0, pausa0, evt0}, {22'd0, exp_vec(m_state[0], m_pulse[0])});
    chk("dut1_outputs", {22'd0, est1, led1, zera1, conta1, pausa1, evt1}, {22'd0, exp_vec(m_state[1], m_pulse[1])});
    if (evt0 === 1'b1) pulses0++;
    if (evt1 === 1'b1) pulses1++;
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the buttons in mask for n sampling edges, release, then let the event settle
  task automatic press(input logic [3:0] mask, input int n);
    @(negedge clk);
    btn = ~mask;
    repeat (n) @(negedge clk);
    btn = 4'hF;
    idle(12);
  endtask

  int p0;

  initial begin
    #1 rst_n = 1'b0;
    idle(3);
    chk("reset_estado", {30'd0, est0}, 32'd0);
    chk("reset_led", {28'd0, led0}, 32'h8);
    chk("reset_zera", {31'd0, zera0}, 32'd1);
    chk("reset_evt_pulse", {31'd0, evt0}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Bounce on count, each level lasting 2 cycles, then released: nothing happens
    p0 = pulses0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn[2] = ~btn[2];
      @(negedge clk);
    end
    idle(12);
    chk("bounce_estado", {30'd0, est0}, 32'd0);
    chk("bounce_pulses", pulses0 - p0, 32'd0);

    // Count press of 10 cycles: state changes on the 7th edge after release
    p0 = pulses0;
    @(negedge clk);
    btn[2] = 1'b0;
    repeat (10) @(negedge clk);
    btn[2] = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("latency_edge6_estado", {30'd0, est0}, 32'd0);
    @(posedge clk);
    #1 chk("latency_edge7_estado", {30'd0, est0}, 32'd1);
    chk("latency_edge7_led", {28'd0, led0}, 32'h4);
    chk("latency_edge7_conta", {31'd0, conta0}, 32'd1);
    chk("latency_edge7_pulse", {31'd0, evt0}, 32'd1);
    idle(8);
    chk("count_single_pulse", pulses0 - p0, 32'd1);

    // Pause toggling, with and without PAUSE_TOGGLE
    press(4'b0010, 8);
    chk("pause_estado", {30'd0, est0}, 32'd2);
    chk("pause_pausa", {31'd0, pausa0}, 32'd1);
    chk("pause_conta", {31'd0, conta0}, 32'd1);
    chk("pause_notoggle_estado", {30'd0, est1}, 32'd2);
    press(4'b0010, 8);
    chk("unpause_estado", {30'd0, est0}, 32'd1);
    chk("notoggle_ignored_estado", {30'd0, est1}, 32'd2);
    press(4'b0100, 8);
    chk("notoggle_count_estado", {30'd0, est1}, 32'd1);

    // Pause held far beyond the debounce time: no event until release
    @(negedge clk);
    btn[1] = 1'b0;
    idle(60);
    chk("held_no_event_estado", {30'd0, est0}, 32'd1);
    btn[1] = 1'b1;
    idle(12);
    chk("held_release_estado", {30'd0, est0}, 32'd2);
    press(4'b0010, 8);
    press(4'b0100, 8);

    // Short and long stop presses, including the LONG boundary
    press(4'b0001, 10);
    chk("stop_short_estado", {30'd0, est0}, 32'd3);
    press(4'b0100, 8);
    chk("parado_count_estado", {30'd0, est0}, 32'd1);
    press(4'b0001, 30);
    chk("stop_long_estado", {30'd0, est0}, 32'd0);
    chk("stop_long_zera", {31'd0, zera0}, 32'd1);
    press(4'b0100, 8);
    press(4'b0001, L - 1);
    chk("stop_below_long_estado", {30'd0, est0}, 32'd3);
    press(4'b0100, 8);
    press(4'b0001, L);
    chk("stop_at_long_estado", {30'd0, est0}, 32'd0);
    press(4'b0100, 8);

    // Simultaneous releases resolved by priority
    press(4'b1100, 8);
    chk("reset_over_count_estado", {30'd0, est0}, 32'd0);
    press(4'b0100, 8);
    press(4'b0011, 8);
    chk("stop_over_pause_estado", {30'd0, est0}, 32'd3);
    chk("stop_over_pause_estado1", {30'd0, est1}, 32'd3);
    press(4'b1000, 8);
    p0 = pulses0;
    press(4'b0010, 8);
    chk("pause_in_reset_estado", {30'd0, est0}, 32'd0);
    chk("pause_in_reset_pulses", pulses0 - p0, 32'd0);

    // Asynchronous reset while counting
    press(4'b0100, 8);
    chk("precount_estado", {30'd0, est0}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_estado", {30'd0, est0}, 32'd0);
    chk("async_led", {28'd0, led0}, 32'h8);
    chk("async_zera", {31'd0, zera0}, 32'd1);
    chk("async_conta", {31'd0, conta0}, 32'd0);
    chk("async_pulse", {31'd0, evt0}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
